// File: rtl/key_debounce_if.sv
// Button bundle between the raw pins, the debouncer and the mode state machines.
// The master drives the raw pins; the slave (the debouncer) returns the conditioned outputs.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] sw_in;
  logic [N_KEYS-1:0] sw_level;
  logic [N_KEYS-1:0] sw_press;
  logic [N_KEYS-1:0] sw_release;

  modport master (output sw_in, input sw_level, input sw_press, input sw_release);
  modport slave  (input sw_in, output sw_level, output sw_press, output sw_release);
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, count-based debounce, press/release strobes.
// Define KEY_AUTOREPEAT_EN to repeat press strobes while a button is held.
module key_debounce #(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 5000000
) (
  input  logic         clk,
  input  logic         rst,
  key_debounce_if.slave kb
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYC - 1);

  // Nonsensical settings are rejected at elaboration rather than misbehaving silently.
  if (DEBOUNCE_CYC < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1 || N_KEYS < 1) begin : g_bad_params
    $error("key_debounce: DEBOUNCE_CYC must be >= 2, REPEAT_DLY/REPEAT_PER/N_KEYS >= 1");
  end

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic [DW-1:0]     dcnt [N_KEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PER - 1);

  logic [RW-1:0]     rcnt [N_KEYS];
  logic [N_KEYS-1:0] rphase;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        dcnt[i] <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt[i] <= '0;
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      rphase <= '0;
`endif
    end else begin
      sync1 <= kb.sw_in;
      sync2 <= sync1;
      for (int i = 0; i < N_KEYS; i++) begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
        if (sync2[i] == level_q[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCNT_MAX) begin
          level_q[i]   <= sync2[i];
          press_q[i]   <= sync2[i];
          release_q[i] <= ~sync2[i];
          dcnt[i]      <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
`ifdef KEY_AUTOREPEAT_EN
        // A release being accepted this cycle wins over a coinciding repeat strobe.
        if (!level_q[i] || (!sync2[i] && dcnt[i] == DCNT_MAX)) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b0;
        end else if (rcnt[i] == (rphase[i] ? PER_MAX : DLY_MAX)) begin
          press_q[i] <= 1'b1;
          rcnt[i]    <= '0;
          rphase[i]  <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + RW'(1);
        end
`endif
      end
    end
  end

  assign kb.sw_level   = level_q;
  assign kb.sw_press   = press_q;
  assign kb.sw_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce with DEBOUNCE_CYC=8, REPEAT_DLY=20, REPEAT_PER=6.
// Expectations follow KEY_AUTOREPEAT_EN when it is defined for the build.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  key_debounce_if #(.N_KEYS(4)) kb ();

  key_debounce #(
    .N_KEYS(4),
    .DEBOUNCE_CYC(8),
    .REPEAT_DLY(20),
    .REPEAT_PER(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kb(kb)
  );

  always #5 clk = ~clk;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] sw);
    kb.sw_in = sw;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] exp_press;

    applyStimulus(4'b0000);
    rst = 1'b1;

    // Reset held for three cycles: everything quiet.
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("reset level c=%0d", c), kb.sw_level, 4'b0000);
      checkOutput($sformatf("reset press c=%0d", c), kb.sw_press, 4'b0000);
      checkOutput($sformatf("reset release c=%0d", c), kb.sw_release, 4'b0000);
    end

    // Clean press on channel 0, driven at edge 0 with reset released.
    rst = 1'b0;
    applyStimulus(4'b0001);
    for (int e = 1; e <= 11; e++) begin
      tick();
      checkOutput($sformatf("clean press e=%0d", e), kb.sw_press, (e == 10) ? 4'b0001 : 4'b0000);
      checkOutput($sformatf("clean level e=%0d", e), kb.sw_level, (e >= 10) ? 4'b0001 : 4'b0000);
      checkOutput($sformatf("clean release e=%0d", e), kb.sw_release, 4'b0000);
    end

    // Release channel 0 to get back to idle.
    applyStimulus(4'b0000);
    for (int e = 1; e <= 11; e++) begin
      tick();
      checkOutput($sformatf("ch0 release e=%0d", e), kb.sw_release, (e == 10) ? 4'b0001 : 4'b0000);
      checkOutput($sformatf("ch0 release press e=%0d", e), kb.sw_press, 4'b0000);
      checkOutput($sformatf("ch0 release level e=%0d", e), kb.sw_level, (e >= 10) ? 4'b0000 : 4'b0001);
    end

    // Bounce on channel 1: 3-cycle pulses 1,0,1,0 must never be accepted.
    for (int p = 0; p < 4; p++) begin
      applyStimulus((p % 2 == 0) ? 4'b0010 : 4'b0000);
      for (int c = 0; c < 3; c++) begin
        tick();
        checkOutput($sformatf("bounce press p=%0d c=%0d", p, c), kb.sw_press, 4'b0000);
        checkOutput($sformatf("bounce level p=%0d c=%0d", p, c), kb.sw_level, 4'b0000);
      end
    end
    applyStimulus(4'b0010);
    for (int e = 1; e <= 11; e++) begin
      tick();
      checkOutput($sformatf("bounce final press e=%0d", e), kb.sw_press, (e == 10) ? 4'b0010 : 4'b0000);
      checkOutput($sformatf("bounce final level e=%0d", e), kb.sw_level, (e >= 10) ? 4'b0010 : 4'b0000);
    end

    // Channel 2 pressed alongside held channel 1, then released.
    applyStimulus(4'b0110);
    for (int e = 1; e <= 11; e++) tick();
    checkOutput("ch2 up level", kb.sw_level, 4'b0110);
    applyStimulus(4'b0010);
    for (int e = 1; e <= 11; e++) begin
      tick();
      checkOutput($sformatf("ch2 release e=%0d", e), kb.sw_release & 4'b0100, (e == 10) ? 4'b0100 : 4'b0000);
      checkOutput($sformatf("ch2 release level e=%0d", e), kb.sw_level & 4'b0100, (e >= 10) ? 4'b0000 : 4'b0100);
      checkOutput($sformatf("ch2 release press e=%0d", e), kb.sw_press & 4'b0100, 4'b0000);
    end
    applyStimulus(4'b0000);
    for (int e = 1; e <= 12; e++) tick();
    checkOutput("idle level", kb.sw_level, 4'b0000);

    // Channels 3 and 0 raised on the same edge strobe together.
    applyStimulus(4'b1001);
    for (int e = 1; e <= 11; e++) begin
      tick();
      checkOutput($sformatf("dual press e=%0d", e), kb.sw_press, (e == 10) ? 4'b1001 : 4'b0000);
      checkOutput($sformatf("dual release e=%0d", e), kb.sw_release, 4'b0000);
    end
    checkOutput("dual level", kb.sw_level, 4'b1001);

    // One-cycle reset with buttons held: fresh press 10 edges after deassertion.
    rst = 1'b1;
    tick();
    checkOutput("midreset level", kb.sw_level, 4'b0000);
    checkOutput("midreset press", kb.sw_press, 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      checkOutput($sformatf("post-reset press e=%0d", e), kb.sw_press, (e == 10) ? 4'b1001 : 4'b0000);
      checkOutput($sformatf("post-reset level e=%0d", e), kb.sw_level, (e >= 10) ? 4'b1001 : 4'b0000);
    end

    // Keep holding: repeats at 30, 36, 42, 48 only with auto-repeat.
    for (int e = 12; e <= 50; e++) begin
      tick();
      exp_press = (AUTOREPEAT && (e == 30 || e == 36 || e == 42 || e == 48)) ? 4'b1001 : 4'b0000;
      checkOutput($sformatf("hold press e=%0d", e), kb.sw_press, exp_press);
    end

    // Drop both at edge 50; one more repeat at 54, release at 60 wins over the repeat due then.
    applyStimulus(4'b0000);
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_press = (AUTOREPEAT && e == 4) ? 4'b1001 : 4'b0000;
      checkOutput($sformatf("drop press e=%0d", e), kb.sw_press, exp_press);
      checkOutput($sformatf("drop release e=%0d", e), kb.sw_release, (e == 10) ? 4'b1001 : 4'b0000);
      checkOutput($sformatf("drop level e=%0d", e), kb.sw_level, (e >= 10) ? 4'b0000 : 4'b1001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner for the four user push-buttons on the watch board. It sits between the raw `sw_in` pins and the mode blocks: the watch display mode and the time-set mode. It synchronises each button and debounces it by clock-count. It then presents a clean level plus single-cycle press and release strobes, so the mode state machines advance exactly once per physical press. It can optionally auto-repeat press strobes while a button is held, for fast time adjustment.

## Interface
Parameters:
- `N_KEYS`, 4, number of independent button channels
- `DEBOUNCE_CYC`, 500000, consecutive clk cycles a new level must persist before it is accepted (10 ms at 50 MHz); minimum 2
- `REPEAT_DLY`, 25000000, clk cycles from accepted press to first repeat strobe (0.5 s); used only with auto-repeat
- `REPEAT_PER`, 5000000, clk cycles between subsequent repeat strobes (0.1 s); used only with auto-repeat

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `sw_in`  in  N_KEYS  raw button inputs, asynchronous to clk, 1 = pressed
- `sw_level`  out  N_KEYS  debounced, registered button state
- `sw_press`  out  N_KEYS  one-clk strobe per accepted press, plus repeat strobes when enabled
- `sw_release`  out  N_KEYS  one-clk strobe per accepted release

## Operation
- Each channel is fully independent; the per-channel logic is replicated `N_KEYS` times.
- Synchroniser: two-flop chain per channel, `sync1 <= sw_in`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Debounce counter `dcnt`, width `$clog2(DEBOUNCE_CYC)`:
  - if `sync2 == sw_level`: `dcnt <= 0`
  - else if `dcnt == DEBOUNCE_CYC-1`: `sw_level <= sync2`, `dcnt <= 0`
  - else: `dcnt <= dcnt + 1`
- A single-cycle bounce back to the stable level clears `dcnt`, and counting restarts from 0 on the next difference.
- Strobes are registered in the same cycle that `sw_level` updates:
  - `sw_press` = 1 for one cycle on a 0→1 update of `sw_level`
  - `sw_release` = 1 for one cycle on a 1→0 update of `sw_level`
  - both are 0 otherwise
- Press and release strobes of one channel can never coincide. Different channels may strobe in the same cycle.

## Timing
- Reset values: `sw_level`, `sw_press`, `sw_release`, the sync flops, `dcnt` and `rcnt` are all 0.
- Latency: a raw change at edge 0 that stays stable updates `sw_level` and fires its strobe at edge `DEBOUNCE_CYC + 2`.
- Timing breakdown: 2 edges of synchroniser, then `DEBOUNCE_CYC` edges of counting.
- Strobe width is exactly one clk cycle.
- Reset mid-count discards the partial count.
- A button held through reset is seen as a fresh press after reset: `sw_press` fires `DEBOUNCE_CYC + 2` edges after `rst` deasserts.
- No counter wraps: `dcnt` saturates at `DEBOUNCE_CYC-1` by construction, and `rcnt` reloads on every repeat.

## Configuration
- Macro: `KEY_AUTOREPEAT_EN`.
- Defined: each channel has a repeat counter `rcnt` sized for `max(REPEAT_DLY, REPEAT_PER)`.
  - Cleared whenever `sw_level` is 0, and on the press update.
  - While `sw_level` is 1 it increments each cycle.
  - On reaching `REPEAT_DLY-1` (first repeat) or `REPEAT_PER-1` (later repeats), it asserts `sw_press` for one cycle and reloads to 0. A phase bit selects which limit applies.
  - Release stops repeating immediately. `sw_release` behaviour is unchanged.
- Undefined: no repeat logic is instantiated, and `sw_press` fires only on the 0→1 update of `sw_level`.

## Test plan
Simulation parameters: `DEBOUNCE_CYC=8`, `REPEAT_DLY=20`, `REPEAT_PER=6`.
- Reset and clean press: hold `rst`=1 for 3 cycles, then drive `sw_in=4'b0001` at edge 0 and hold. Expect all outputs 0 during reset, `sw_level[0]`=1 and `sw_press[0]`=1 for exactly one cycle at edge 10, and no other bits active.
- Bounce rejection: toggle `sw_in[1]` 1,0,1,0 with 3-cycle pulses, then hold it at 1. Expect no strobe during the bounce, and a single `sw_press[1]` 10 edges after the final rising transition.
- Release: from `sw_level[2]`=1, drop `sw_in[2]`. Expect `sw_release[2]` for one cycle 10 edges later, and `sw_level[2]`=0.
- Simultaneous and independent channels: raise `sw_in[3]` and `sw_in[0]` on the same edge. Expect both `sw_press` bits in the same cycle.
- Reset mid-operation: with `sw_in[0]` held at 1, pulse `rst` for 1 cycle. Expect `sw_level[0]`=0 immediately, then `sw_press[0]` again 10 edges after `rst` deasserts.
- Auto-repeat (with `KEY_AUTOREPEAT_EN`): hold `sw_in[0]`=1. Expect press strobes at edges 10, 30, 36, 42, …; after release, no further press strobes. Without the macro, expect only the strobe at edge 10.
